// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one multiplier and one accumulator step through ORDER taps per sample.
// Coefficients are double-buffered; a commit lands only while no sample is in flight.
module fir_mac_sequencer #(
    parameter int unsigned ORDER  = 64,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned COEF_W = 32,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned AW     = $clog2(ORDER)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    input  logic              coef_wr_en,
    input  logic [AW-1:0]     coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    input  logic              coef_commit,
    output logic              coef_pending,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       k_q, k_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    prod_q, prod_d;
    logic                prod_vld_q, prod_vld_d;
    logic                out_valid_q, out_valid_d;
    logic [ACC_W-1:0]    out_data_q, out_data_d;
    logic                pending_q, pending_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   samp_q [ORDER];
    logic [DATA_W-1:0]   samp_d [ORDER];
    logic [COEF_W-1:0]   coef_shd_q [ORDER];
    logic [COEF_W-1:0]   coef_shd_d [ORDER];
    logic [COEF_W-1:0]   coef_act_q [ORDER];
    logic [COEF_W-1:0]   coef_act_d [ORDER];

    logic [AW-1:0]           rd_idx;
    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] samp_ext;

    assign in_ready     = (state_q == StIdle) && !reset;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign coef_pending = pending_q;
    assign busy         = busy_q;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        samp_d      = samp_q;
        coef_shd_d  = coef_shd_q;
        coef_act_d  = coef_act_q;

        // Only the low ACC_W bits of the product survive, so operands are sized to ACC_W first.
        rd_idx   = wr_ptr_q - k_q;
        coef_ext = ACC_W'($signed(coef_act_q[k_q]));
        samp_ext = ACC_W'($signed(samp_q[rd_idx]));

        // Product is registered one cycle ahead of the accumulate.
        if (prod_vld_q) begin
            acc_d = acc_q + prod_q;
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    samp_d[wr_ptr_q] = in_data;
                    acc_d            = '0;
                    k_d              = '0;
                    state_d          = StAccum;
                end
            end
            StAccum: begin
                prod_d     = coef_ext * samp_ext;
                prod_vld_d = 1'b1;
                k_d        = k_q + AW'(1);
                if (k_q == AW'(ORDER - 1)) begin
                    state_d  = StOutput;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end
            StOutput: begin
                if (prod_vld_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_d;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (coef_wr_en) begin
            coef_shd_d[coef_wr_addr] = coef_wr_data;
        end

        pending_d = pending_q | coef_commit;
        if (pending_d && (state_q == StIdle || (state_q == StOutput && state_d == StIdle))) begin
            coef_act_d = coef_shd_d;
            pending_d  = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                samp_q[i]     <= '0;
                coef_shd_q[i] <= '0;
                coef_act_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            samp_q      <= samp_d;
            coef_shd_q  <= coef_shd_d;
            coef_act_q  <= coef_act_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: random samples and coefficients checked against a
// convolution model over the sample history and the two coefficient banks.
module tb_fir_mac_sequencer;

    localparam int ORDER  = 64;
    localparam int DATA_W = 32;
    localparam int COEF_W = 32;
    localparam int ACC_W  = 32;
    localparam int AW     = 6;

    logic              clk          = 1'b0;
    logic              reset        = 1'b1;
    logic              in_valid     = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data      = '0;
    logic              out_valid;
    logic              out_ready    = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic              coef_wr_en   = 1'b0;
    logic [AW-1:0]     coef_wr_addr = '0;
    logic [COEF_W-1:0] coef_wr_data = '0;
    logic              coef_commit  = 1'b0;
    logic              coef_pending;
    logic              busy;

    fir_mac_sequencer #(
        .ORDER  (ORDER),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W),
        .AW     (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .coef_commit  (coef_commit),
        .coef_pending (coef_pending),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // m_x[k] is x[n-k]; entries never written since reset stay zero.
    logic [31:0] m_x   [ORDER];
    logic [31:0] m_shd [ORDER];
    logic [31:0] m_act [ORDER];
    bit          m_pending;
    bit          m_busy;
    logic [31:0] m_exp;
    int unsigned acc_cyc;
    logic [31:0] got;

    function automatic logic [31:0] model_y();
        logic [31:0] s;
        longint      p;
        s = '0;
        for (int k = 0; k < ORDER; k++) begin
            p = longint'($signed(m_act[k])) * longint'($signed(m_x[k]));
            s = s + p[31:0];
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < ORDER; k++) begin
            m_x[k]   = '0;
            m_shd[k] = '0;
            m_act[k] = '0;
        end
        m_pending = 1'b0;
        m_busy    = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] x);
        for (int k = ORDER - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0]  = x;
        m_exp   = model_y();
        m_busy  = 1'b1;
        acc_cyc = cyc;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int addr, input logic [31:0] data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(addr);
        coef_wr_data = data;
        tick();
        coef_wr_en   = 1'b0;
        m_shd[addr]  = data;
    endtask

    task automatic commit_pulse();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        m_pending   = 1'b1;
        if (!m_busy) begin
            m_act     = m_shd;
            m_pending = 1'b0;
        end
    endtask

    task automatic start_sample(input logic [31:0] x);
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL start_wait: in_ready got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom();
        model_accept(x);
    endtask

    task automatic finish_sample(input int hold, output logic [31:0] res);
        int          n = 0;
        int          lat;
        bit          rdy_bad = 1'b0;
        logic [31:0] held;
        out_ready = (hold == 0);
        while (out_valid !== 1'b1 && n < 300) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL out_wait: out_valid got %b want 1 within 300 cycles", out_valid);
            res = out_data;
            return;
        end
        checks++;
        if (rdy_bad) begin
            errors++;
            $display("FAIL busy_phase: in_ready/busy got wrong value want in_ready=0 busy=1");
        end
        lat = int'(cyc - acc_cyc);
        checks++;
        if (lat !== ORDER + 1) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", lat, ORDER + 1);
        end
        checks++;
        if (out_data !== m_exp) begin
            errors++;
            $display("FAIL out_data: got %h want %h", out_data, m_exp);
        end
        checks++;
        if (coef_pending !== m_pending) begin
            errors++;
            $display("FAIL pending_at_out: got %b want %b", coef_pending, m_pending);
        end
        res  = out_data;
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold: got valid=%b data=%h rdy=%b want valid=1 data=%h rdy=0",
                         out_valid, out_data, in_ready, held);
            end
        end
        out_ready = 1'b1;
        tick();
        m_busy = 1'b0;
        if (m_pending) begin
            m_act     = m_shd;
            m_pending = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || coef_pending !== m_pending) begin
            errors++;
            $display("FAIL release: got valid=%b rdy=%b busy=%b pend=%b want 0 1 0 %b",
                     out_valid, in_ready, busy, coef_pending, m_pending);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || coef_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b busy=%b pend=%b want 0 0 0",
                     out_valid, busy, coef_pending);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
        start_sample($urandom());
        finish_sample(0, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL zero_coef: got %h want 0", got);
        end
    endtask

    task automatic test_impulse();
        apply_reset();
        for (int k = 0; k < ORDER; k++) write_coef(k, 32'(k + 1));
        commit_pulse();
        checks++;
        if (coef_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_commit: pending got %b want 0", coef_pending);
        end
        for (int i = 0; i <= ORDER; i++) begin
            start_sample(i == 0 ? 32'd1 : 32'd0);
            finish_sample(0, got);
            checks++;
            if (got !== ((i < ORDER) ? 32'(i + 1) : 32'd0)) begin
                errors++;
                $display("FAIL impulse[%0d]: got %h want %h", i, got,
                         (i < ORDER) ? 32'(i + 1) : 32'd0);
            end
        end
    endtask

    task automatic test_signed_wrap();
        apply_reset();
        write_coef(0, 32'hFFFF_FD04);
        commit_pulse();
        start_sample(32'h7FFF_FFFF);
        finish_sample(0, got);
        checks++;
        if (got !== 32'h0000_02FC) begin
            errors++;
            $display("FAIL wrap_max: got %h want 000002fc", got);
        end
        start_sample(32'hFFFF_FFFF);
        finish_sample(0, got);
        checks++;
        if (got !== 32'h0000_02FC) begin
            errors++;
            $display("FAIL wrap_neg1: got %h want 000002fc", got);
        end
        write_coef(0, 32'hFFFF_FD03);
        commit_pulse();
        start_sample(32'h7FFF_FFFF);
        finish_sample(0, got);
        checks++;
        if (got !== 32'h8000_02FD) begin
            errors++;
            $display("FAIL wrap_odd: got %h want 800002fd", got);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 8; k++) write_coef(k, $urandom());
        commit_pulse();
        start_sample($urandom());
        finish_sample(10, got);
    endtask

    task automatic test_commit_during_accum();
        logic [31:0] x0;
        logic [31:0] x1;
        apply_reset();
        for (int k = 0; k < ORDER; k++) write_coef(k, 32'd1);
        commit_pulse();
        x0 = $urandom();
        x1 = $urandom();
        start_sample(x0);
        repeat (5) tick();
        for (int k = 0; k < 16; k++) write_coef(k, 32'd2);
        commit_pulse();
        checks++;
        if (coef_pending !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accum_commit: got pend=%b busy=%b want 1 1", coef_pending, busy);
        end
        finish_sample(0, got);
        checks++;
        if (got !== x0) begin
            errors++;
            $display("FAIL old_bank: got %h want %h", got, x0);
        end
        start_sample(x1);
        finish_sample(0, got);
        checks++;
        if (got !== 32'(2 * x1 + 2 * x0)) begin
            errors++;
            $display("FAIL new_bank: got %h want %h", got, 32'(2 * x1 + 2 * x0));
        end
    endtask

    task automatic test_same_edge_commit();
        logic [31:0] x;
        logic [31:0] d;
        int          n = 0;
        x = $urandom();
        d = $urandom();
        while (in_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_wait: in_ready got %b want 1", in_ready);
        end
        in_valid     = 1'b1;
        in_data      = x;
        coef_wr_en   = 1'b1;
        coef_wr_addr = '0;
        coef_wr_data = d;
        coef_commit  = 1'b1;
        tick();
        in_valid    = 1'b0;
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        m_shd[0]    = d;
        m_act       = m_shd;
        m_pending   = 1'b0;
        model_accept(x);
        checks++;
        if (coef_pending !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_state: got pend=%b busy=%b want 0 1", coef_pending, busy);
        end
        finish_sample(0, got);
    endtask

    task automatic test_reset_mid_accum();
        logic [31:0] c [4];
        bit          seen = 1'b0;
        apply_reset();
        for (int k = 0; k < ORDER; k++) write_coef(k, $urandom());
        commit_pulse();
        start_sample($urandom());
        repeat (30) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        repeat (100) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_discard: out_valid got 1 want 0");
        end
        checks++;
        if (busy !== 1'b0 || coef_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flags: got busy=%b pend=%b want 0 0", busy, coef_pending);
        end
        for (int k = 0; k < 4; k++) begin
            c[k] = $urandom();
            write_coef(k, c[k]);
        end
        commit_pulse();
        for (int i = 0; i < 6; i++) begin
            start_sample(i == 0 ? 32'd1 : 32'd0);
            finish_sample(0, got);
            checks++;
            if (got !== ((i < 4) ? c[i] : 32'd0)) begin
                errors++;
                $display("FAIL post_reset_impulse[%0d]: got %h want %h", i, got,
                         (i < 4) ? c[i] : 32'd0);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) write_coef(int'($urandom_range(0, ORDER - 1)), $urandom());
                if ($urandom_range(0, 1) == 1) commit_pulse();
            end
            start_sample($urandom());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) write_coef(int'($urandom_range(0, ORDER - 1)), $urandom());
                commit_pulse();
            end
            finish_sample(int'($urandom_range(0, 3)), got);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_signed_wrap();
        test_backpressure();
        test_commit_during_accum();
        test_same_edge_commit();
        test_reset_mid_accum();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
